// File: rtl/pipe_pkg.sv
// Shared ID/EX pipeline definitions: control-bit indices, field widths and
// payload field offsets. Used by the decode and execute stages as well as the
// ID/EX skid register.
package pipe_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int REG_W_DEF  = 4;
    localparam int CTRL_W_DEF = 5;

    // Control bit positions inside the CTRL_W vector {wb_en, mem_rd, mem_wr, branch, s}
    localparam int CTRL_WB_EN  = 4;
    localparam int CTRL_MEM_RD = 3;
    localparam int CTRL_MEM_WR = 2;
    localparam int CTRL_BRANCH = 1;
    localparam int CTRL_S      = 0;

    localparam int IMM_W      = 1;
    localparam int SHIFT_OP_W = 12;
    localparam int SIMM24_W   = 24;

    localparam int PAY_W_DEF = 2*REG_W_DEF + 3*DATA_W_DEF + IMM_W + SHIFT_OP_W + SIMM24_W;

    // Field LSB offsets, packed MSB-first as
    // {cmd, pc, val_rn, val_rm, imm, shift_op, simm24, dest, status}.
    // With the default PAY_W the cmd field lies above the top bit; an
    // instance that needs cmd in the payload uses PAY_W_DEF + REG_W_DEF.
    localparam int STATUS_LSB   = 0;
    localparam int DEST_LSB     = STATUS_LSB + REG_W_DEF;
    localparam int SIMM24_LSB   = DEST_LSB + REG_W_DEF;
    localparam int SHIFT_OP_LSB = SIMM24_LSB + SIMM24_W;
    localparam int IMM_LSB      = SHIFT_OP_LSB + SHIFT_OP_W;
    localparam int VAL_RM_LSB   = IMM_LSB + IMM_W;
    localparam int VAL_RN_LSB   = VAL_RM_LSB + DATA_W_DEF;
    localparam int PC_LSB       = VAL_RN_LSB + DATA_W_DEF;
    localparam int CMD_LSB      = PC_LSB + DATA_W_DEF;

    typedef struct packed {
        logic wb_en;
        logic mem_rd;
        logic mem_wr;
        logic branch;
        logic s;
    } ctrl_t;

    function automatic logic [DATA_W_DEF-1:0] pay_pc(input logic [PAY_W_DEF-1:0] p);
        return p[PC_LSB +: DATA_W_DEF];
    endfunction

    function automatic logic [PAY_W_DEF-1:0] pay_set_pc(input logic [PAY_W_DEF-1:0] p,
                                                         input logic [DATA_W_DEF-1:0] pc);
        logic [PAY_W_DEF-1:0] r;
        r = p;
        r[PC_LSB +: DATA_W_DEF] = pc;
        return r;
    endfunction

endpackage

// File: rtl/skid_entry.sv
// One pipeline slot: valid bit, control bits and payload. Clear drops the
// entry and zeroes its control bits but keeps the payload; reset zeroes all.
module skid_entry
    import pipe_pkg::*;
#(
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int PAY_W  = PAY_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              load,
    input  logic [CTRL_W-1:0] d_ctrl,
    input  logic [PAY_W-1:0]  d_payload,
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic [PAY_W-1:0]  payload
);

    // Slot register: reset, then clear, then load.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid   <= 1'b0;
            ctrl    <= '0;
            payload <= '0;
        end else if (clear) begin
            valid <= 1'b0;
            ctrl  <= '0;
        end else if (load) begin
            valid   <= 1'b1;
            ctrl    <= d_ctrl;
            payload <= d_payload;
        end
    end

endmodule

// File: rtl/id_ex_skid_reg.sv
// ID/EX pipeline register with a one-deep skid buffer. in_ready depends only
// on registered state and hazard, so out_ready never reaches back to decode.
module id_ex_skid_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_W  = REG_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int PAY_W  = 2*REG_W + 3*DATA_W + 1 + 12 + 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              hazard,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [PAY_W-1:0]  in_payload,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [PAY_W-1:0]  out_payload,
    output logic [1:0]        occupancy
);

    logic              head_valid;
    logic [CTRL_W-1:0] head_ctrl;
    logic [PAY_W-1:0]  head_payload;
    logic              skid_valid;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [PAY_W-1:0]  skid_payload;

    logic              accept;
    logic              pop;
    logic              head_load;
    logic              head_clear;
    logic              skid_load;
    logic              skid_clear;
    logic [CTRL_W-1:0] head_d_ctrl;
    logic [PAY_W-1:0]  head_d_payload;

    // Handshake decode and slot steering. A full skid forces in_ready low,
    // so accept and skid-to-head promotion never coincide.
    always_comb begin
        in_ready   = ~skid_valid & ~hazard;
        accept     = in_valid & in_ready & ~flush;
        pop        = head_valid & out_ready & ~flush;

        head_load  = (pop & skid_valid) | (accept & (~head_valid | pop));
        head_clear = flush | (pop & ~skid_valid & ~accept);
        skid_load  = accept & head_valid & ~pop;
        skid_clear = flush | (pop & skid_valid);

        head_d_ctrl    = in_ctrl;
        head_d_payload = in_payload;
        if (skid_valid) begin
            head_d_ctrl    = skid_ctrl;
            head_d_payload = skid_payload;
        end
    end

    skid_entry #(.CTRL_W(CTRL_W), .PAY_W(PAY_W)) u_head (
        .clk       (clk),
        .rst       (rst),
        .clear     (head_clear),
        .load      (head_load),
        .d_ctrl    (head_d_ctrl),
        .d_payload (head_d_payload),
        .valid     (head_valid),
        .ctrl      (head_ctrl),
        .payload   (head_payload)
    );

    skid_entry #(.CTRL_W(CTRL_W), .PAY_W(PAY_W)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .clear     (skid_clear),
        .load      (skid_load),
        .d_ctrl    (in_ctrl),
        .d_payload (in_payload),
        .valid     (skid_valid),
        .ctrl      (skid_ctrl),
        .payload   (skid_payload)
    );

    // Head slot drives execute; its control bits are zero whenever it is empty.
    always_comb begin
        out_valid   = head_valid;
        out_ctrl    = head_valid ? head_ctrl : '0;
        out_payload = head_payload;
        occupancy   = {1'b0, head_valid} + {1'b0, skid_valid};
    end

endmodule

// File: tb/tb_id_ex_skid_reg.sv
// Bench for id_ex_skid_reg: a cycle table of directed scenarios, then random
// traffic checked against a FIFO-of-two reference model.
module tb_id_ex_skid_reg;
    import pipe_pkg::*;

    localparam int DW = DATA_W_DEF;
    localparam int CW = CTRL_W_DEF;
    localparam int PW = PAY_W_DEF;

    logic          clk = 1'b0;
    logic          rst, flush, hazard, in_valid, in_ready, out_valid, out_ready;
    logic [CW-1:0] in_ctrl, out_ctrl;
    logic [PW-1:0] in_payload, out_payload;
    logic [1:0]    occupancy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    id_ex_skid_reg dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .hazard      (hazard),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_ctrl     (in_ctrl),
        .in_payload  (in_payload),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_ctrl    (out_ctrl),
        .out_payload (out_payload),
        .occupancy   (occupancy)
    );

    // Reference model: ordered list of held instructions, at most two.
    typedef struct {
        logic [CW-1:0] ctrl;
        logic [PW-1:0] pay;
    } ent_t;
    ent_t          q[$];
    logic [PW-1:0] last_pay = '0;

    task automatic model_edge();
        int   n;
        bit   acc;
        ent_t e;
        if (rst) begin
            q.delete();
            last_pay = '0;
        end else if (flush) begin
            q.delete();
        end else begin
            n   = q.size();
            acc = in_valid && (n < 2) && !hazard;
            if (n > 0 && out_ready) void'(q.pop_front());
            if (acc) begin
                e.ctrl = in_ctrl;
                e.pay  = in_payload;
                q.push_back(e);
            end
        end
        if (q.size() > 0) last_pay = q[0].pay;
    endtask

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        check("rnd_out_valid", 160'(out_valid), 160'(q.size() > 0));
        check("rnd_occupancy", 160'(occupancy), 160'(q.size()));
        check("rnd_in_ready", 160'(in_ready), 160'((q.size() < 2) && !hazard));
        check("rnd_out_ctrl", 160'(out_ctrl), (q.size() > 0) ? 160'(q[0].ctrl) : 160'(0));
        check("rnd_out_payload", 160'(out_payload), (q.size() > 0) ? 160'(q[0].pay) : 160'(last_pay));
    endtask

    // One clock: inputs already driven; advance past the edge and update the model.
    task automatic clock_step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    function automatic logic [PW-1:0] mk_pay(input logic [DW-1:0] pc);
        logic [PW-1:0] p;
        p        = '0;
        p[31:0]  = ~pc;
        return pay_set_pc(p, pc);
    endfunction

    typedef struct {
        bit            rst, flush, hz, iv, ordy;
        logic [CW-1:0] ctrl;
        logic [DW-1:0] pc;
        bit            chk;
        bit            ov;
        logic [1:0]    occ;
        bit            ir;
        logic [CW-1:0] ectrl;
        logic [DW-1:0] epc;
        bit            pz;
    } vec_t;

    function automatic vec_t v(bit r, bit f, bit h, bit iv, bit ordy, logic [CW-1:0] c,
                               logic [DW-1:0] pc, bit chk, bit ov, logic [1:0] occ,
                               bit ir, logic [CW-1:0] ec, logic [DW-1:0] epc, bit pz);
        vec_t x;
        x.rst = r; x.flush = f; x.hz = h; x.iv = iv; x.ordy = ordy;
        x.ctrl = c; x.pc = pc; x.chk = chk; x.ov = ov; x.occ = occ;
        x.ir = ir; x.ectrl = ec; x.epc = epc; x.pz = pz;
        return x;
    endfunction

    localparam logic [CW-1:0] C  = 5'b10101;
    localparam logic [CW-1:0] CA = 5'b11111;

    vec_t tbl[$];

    initial begin
        logic [159:0] r;

        rst = 1'b1; flush = 1'b0; hazard = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_ctrl = '0; in_payload = '0;

        //        rst f h iv or ctrl pc       chk ov occ ir ectrl epc   pz
        // reset held two cycles with in_valid high
        tbl.push_back(v(1, 0, 0, 1, 0, C,  32'hAA, 0, 0, 0, 1, 0,  0,     0));
        tbl.push_back(v(1, 0, 0, 1, 0, C,  32'hAA, 1, 0, 0, 1, 0,  0,     1));
        tbl.push_back(v(0, 0, 0, 0, 1, C,  32'h0,  1, 0, 0, 1, 0,  0,     1));
        // streaming pc 0,4,8,12
        tbl.push_back(v(0, 0, 0, 1, 1, C,  32'h0,  1, 0, 0, 1, 0,  0,     0));
        tbl.push_back(v(0, 0, 0, 1, 1, C,  32'h4,  1, 1, 1, 1, C,  32'h0, 0));
        tbl.push_back(v(0, 0, 0, 1, 1, C,  32'h8,  1, 1, 1, 1, C,  32'h4, 0));
        tbl.push_back(v(0, 0, 0, 1, 1, C,  32'hC,  1, 1, 1, 1, C,  32'h8, 0));
        tbl.push_back(v(0, 0, 0, 0, 1, C,  32'h0,  1, 1, 1, 1, C,  32'hC, 0));
        tbl.push_back(v(0, 0, 0, 0, 1, C,  32'h0,  1, 0, 0, 1, 0,  0,     0));
        // backpressure 0x10,0x14,0x18
        tbl.push_back(v(0, 0, 0, 1, 0, C,  32'h10, 1, 0, 0, 1, 0,  0,     0));
        tbl.push_back(v(0, 0, 0, 1, 0, C,  32'h14, 1, 1, 1, 1, C,  32'h10, 0));
        tbl.push_back(v(0, 0, 0, 1, 0, C,  32'h18, 1, 1, 2, 0, C,  32'h10, 0));
        tbl.push_back(v(0, 0, 0, 1, 0, C,  32'h18, 1, 1, 2, 0, C,  32'h10, 0));
        tbl.push_back(v(0, 0, 0, 1, 1, C,  32'h18, 1, 1, 2, 0, C,  32'h10, 0));
        tbl.push_back(v(0, 0, 0, 1, 1, C,  32'h18, 1, 1, 1, 1, C,  32'h14, 0));
        tbl.push_back(v(0, 0, 0, 0, 1, C,  32'h0,  1, 1, 1, 1, C,  32'h18, 0));
        tbl.push_back(v(0, 0, 0, 0, 1, C,  32'h0,  1, 0, 0, 1, 0,  0,     0));
        // hazard for two cycles with all control bits set
        tbl.push_back(v(0, 0, 1, 1, 1, CA, 32'h20, 1, 0, 0, 0, 0,  0,     0));
        tbl.push_back(v(0, 0, 1, 1, 1, CA, 32'h20, 1, 0, 0, 0, 0,  0,     0));
        tbl.push_back(v(0, 0, 0, 1, 1, CA, 32'h20, 1, 0, 0, 1, 0,  0,     0));
        tbl.push_back(v(0, 0, 0, 0, 1, C,  32'h0,  1, 1, 1, 1, CA, 32'h20, 0));
        tbl.push_back(v(0, 0, 0, 0, 1, C,  32'h0,  1, 0, 0, 1, 0,  0,     0));
        // flush with occupancy 2 and an incoming instruction
        tbl.push_back(v(0, 0, 0, 1, 0, C,  32'h30, 1, 0, 0, 1, 0,  0,     0));
        tbl.push_back(v(0, 0, 0, 1, 0, C,  32'h34, 1, 1, 1, 1, C,  32'h30, 0));
        tbl.push_back(v(0, 1, 0, 1, 0, C,  32'h38, 1, 1, 2, 0, C,  32'h30, 0));
        tbl.push_back(v(0, 0, 0, 0, 1, C,  32'h0,  1, 0, 0, 1, 0,  0,     0));
        tbl.push_back(v(0, 0, 0, 0, 1, C,  32'h0,  1, 0, 0, 1, 0,  0,     0));
        // flush while in_ready is high discards the offered instruction
        tbl.push_back(v(0, 0, 0, 1, 0, C,  32'h40, 1, 0, 0, 1, 0,  0,     0));
        tbl.push_back(v(0, 1, 0, 1, 0, C,  32'h44, 1, 1, 1, 1, C,  32'h40, 0));
        tbl.push_back(v(0, 0, 0, 0, 1, C,  32'h0,  1, 0, 0, 1, 0,  0,     0));
        // reset mid-operation at occupancy 2 with out_ready high
        tbl.push_back(v(0, 0, 0, 1, 0, C,  32'h50, 1, 0, 0, 1, 0,  0,     0));
        tbl.push_back(v(0, 0, 0, 1, 0, C,  32'h54, 1, 1, 1, 1, C,  32'h50, 0));
        tbl.push_back(v(1, 0, 0, 0, 1, C,  32'h0,  1, 1, 2, 0, C,  32'h50, 0));
        tbl.push_back(v(0, 0, 0, 0, 1, C,  32'h0,  1, 0, 0, 1, 0,  0,     1));
        tbl.push_back(v(0, 0, 0, 0, 1, C,  32'h0,  1, 0, 0, 1, 0,  0,     1));

        @(negedge clk);
        foreach (tbl[i]) begin
            rst = tbl[i].rst; flush = tbl[i].flush; hazard = tbl[i].hz;
            in_valid = tbl[i].iv; out_ready = tbl[i].ordy;
            in_ctrl = tbl[i].ctrl; in_payload = mk_pay(tbl[i].pc);
            #1;
            if (tbl[i].chk) begin
                check($sformatf("vec%0d_out_valid", i), 160'(out_valid), 160'(tbl[i].ov));
                check($sformatf("vec%0d_occupancy", i), 160'(occupancy), 160'(tbl[i].occ));
                check($sformatf("vec%0d_in_ready", i), 160'(in_ready), 160'(tbl[i].ir));
                check($sformatf("vec%0d_out_ctrl", i), 160'(out_ctrl), 160'(tbl[i].ectrl));
                if (tbl[i].ov)
                    check($sformatf("vec%0d_out_pc", i), 160'(pay_pc(out_payload)), 160'(tbl[i].epc));
                if (tbl[i].pz)
                    check($sformatf("vec%0d_out_payload_zero", i), 160'(out_payload), 160'(0));
            end
            clock_step();
        end

        // Randomized traffic against the queue model.
        for (int k = 0; k < 4000; k++) begin
            rst       = ($urandom_range(0, 99) == 0);
            flush     = ($urandom_range(0, 19) == 0);
            hazard    = ($urandom_range(0, 4) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_ctrl   = CW'($urandom);
            r = {$urandom, $urandom, $urandom, $urandom, $urandom};
            in_payload = r[PW-1:0];
            #1;
            check_model();
            clock_step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/id_ex_skid_reg.md
ID_EX_SKID_REG -- requirements
Module: id_ex_skid_reg

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, width of PC and operand values.
REQ-002 The block SHALL have parameter REG_W, default 4, width of register addresses, exec command and status flags.
REQ-003 The block SHALL have parameter CTRL_W, default 5, control bits {wb_en, mem_rd, mem_wr, branch, s}, bit 4 = wb_en.
REQ-004 The block SHALL have parameter PAY_W, default 2*REG_W+3*DATA_W+1+12+24, packed {cmd, pc, val_rn, val_rm, imm, shift_op, simm24, dest, status}.
REQ-005 The block SHALL have port clk, input, 1, sole clock, all state on rising edge.
REQ-006 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 The block SHALL have port flush, input, 1, kill all held and incoming instructions.
REQ-008 The block SHALL have port hazard, input, 1, decode stall; insert a bubble, block upstream.
REQ-009 The block SHALL have port in_valid, input, 1, decode offers an instruction.
REQ-010 The block SHALL have port in_ready, output, 1, block accepts this cycle.
REQ-011 The block SHALL have port in_ctrl, input, CTRL_W, decoded control bits.
REQ-012 The block SHALL have port in_payload, input, PAY_W, decoded data fields.
REQ-013 The block SHALL have port out_valid, output, 1, execute stage has a valid instruction.
REQ-014 The block SHALL have port out_ready, input, 1, execute consumes this cycle.
REQ-015 The block SHALL have port out_ctrl, output, CTRL_W, control bits of head entry.
REQ-016 The block SHALL have port out_payload, output, PAY_W, data of head entry.
REQ-017 The block SHALL have port occupancy, output, 2, held entries 0..2.

Function
REQ-018 The block SHALL hold two entries, head (main) and skid, head always drives out_* ports.
REQ-019 in_ready SHALL equal ~skid_valid & ~hazard, derived from registered state and hazard only, never from out_ready.
REQ-020 Accept SHALL occur when in_valid & in_ready & ~flush; accepted data visible on out_* the next cycle (latency 1).
REQ-021 Pop SHALL occur when out_valid & out_ready; on pop the skid entry, if valid, SHALL move to head in the same edge.
REQ-022 Accept with head empty, or head popped and skid empty, SHALL write head; otherwise SHALL write skid.
REQ-023 Simultaneous accept and pop with occupancy 2 SHALL not occur (in_ready low); with occupancy 1 occupancy SHALL stay 1.
REQ-024 Entries SHALL leave in acceptance order; no entry SHALL be dropped or duplicated except by flush.
REQ-025 out_ctrl SHALL be all-zero whenever out_valid=0 (bubble carries no wb/mem/branch/s side effects).
REQ-026 out_payload SHALL hold its last value when out_valid=0.
REQ-027 flush SHALL clear both valid bits on the next edge, discard the same-cycle input, and override accept, pop and hazard.
REQ-028 hazard with in_valid=1 SHALL cause no accept; held entries SHALL still drain on out_ready.
REQ-029 occupancy SHALL equal head_valid + skid_valid.

Reset
REQ-030 rst SHALL, on the clock edge, clear head and skid valid bits, zero out_ctrl, out_payload and occupancy, and set in_ready=~hazard the next cycle.
REQ-031 rst SHALL take priority over flush, accept and pop, and SHALL abort any in-flight entry.

Structure
REQ-032 Control-bit index constants, field widths and the payload pack/unpack field offsets SHALL live in shared package pipe_pkg, reused by the ID and EX stages.
REQ-033 One sub-module, skid_entry (valid, ctrl, payload register with load and clear), SHALL be instantiated twice.

Verification
REQ-034 Reset: rst=1 two cycles with in_valid=1 -> out_valid=0, out_ctrl=0, occupancy=0, in_ready=1 after release.
REQ-035 Streaming: out_ready=1, 4 back-to-back instructions with pc 0,4,8,12 -> out pc 0,4,8,12 on consecutive cycles, occupancy never above 1.
REQ-036 Backpressure: out_ready=0, send pc 0x10,0x14,0x18 -> occupancy 2, in_ready=0, pc 0x18 held upstream; out_ready=1 -> 0x10,0x14,0x18 in order.
REQ-037 Hazard: hazard=1 for 2 cycles with in_ctrl=5'b11111 -> in_ready=0, out_valid=0, out_ctrl=0 for 2 cycles, then instruction emerges once.
REQ-038 Flush: occupancy 2 plus in_valid=1, flush=1 one cycle -> next cycle out_valid=0, occupancy=0; none of the three instructions ever appear.
REQ-039 Reset mid-operation: occupancy 2 and out_ready=1 with rst=1 -> next cycle occupancy=0, no pop observed.
